// File: rtl/ids_input_arbiter.sv
// ids_input_arbiter: packet-granular round-robin arbiter that shares one IDS
// pattern-match pipeline between NUM_QUEUES sources. Each source has a small
// fallthrough buffer; the grant is held for a whole packet, and words are
// registered toward the IDS stage one cycle after they leave a buffer.
module ids_input_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_QUEUES      = 4,
    parameter int QIDX_WIDTH      = 2,
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic [NUM_QUEUES-1:0]            queue_en,
    output logic [NUM_QUEUES-1:0]            grant,
    output logic [QIDX_WIDTH-1:0]            cur_src,
    output logic                             pkt_done,
    output logic [NUM_QUEUES-1:0]            overflow
);

    localparam int DEPTH      = 1 << FIFO_DEPTH_BITS;
    localparam int WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;
    localparam int CNT_WIDTH  = FIFO_DEPTH_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WORD_WIDTH-1:0]      mem    [NUM_QUEUES][DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr [NUM_QUEUES];
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]       count  [NUM_QUEUES];

    logic [NUM_QUEUES-1:0] empty, full, nearly_full, push, pop_vec, eligible;
    logic                  pop, eop_pop;
    logic [WORD_WIDTH-1:0] head_word;
    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;

    logic                  rr_found;
    logic [QIDX_WIDTH-1:0] rr_pick, rr_idx;
    logic [NUM_QUEUES-1:0] grant_next;
    logic [QIDX_WIDTH-1:0] cur_src_next;

    // Per-source buffer status flags and accepted writes.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        empty       = '0;
        full        = '0;
        nearly_full = '0;
        push        = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            empty[i]       = (count[i] == '0);
            full[i]        = (count[i] == CNT_WIDTH'(DEPTH));
            nearly_full[i] = (count[i] >= CNT_WIDTH'(DEPTH - 1));
            // A full buffer still accepts a write when it is popped in the same cycle.
            push[i]        = in_wr[i] && (!full[i] || pop_vec[i]);
        end
    end

    assign in_rdy    = ~nearly_full;
    assign eligible  = queue_en & ~empty;
    assign pop       = (state != IDLE) && !empty[cur_src] && out_rdy;
    assign pop_vec   = pop ? (NUM_QUEUES'(1) << cur_src) : '0;
    assign head_word = mem[cur_src][rd_ptr[cur_src]];
    assign head_ctrl = head_word[WORD_WIDTH-1 -: CTRL_WIDTH];
    assign head_data = head_word[DATA_WIDTH-1:0];
    assign eop_pop   = (state == BODY) && pop && (head_ctrl != '0);

    // Buffer storage: written on accepted pushes only.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; the reset pointers and counts make stale contents unreachable.
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH],
                                      in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // Buffer pointers, occupancy and sticky overflow flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (push[i])    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop_vec[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_WIDTH'(push[i]) - CNT_WIDTH'(pop_vec[i]);
                if (in_wr[i] && full[i] && !pop_vec[i]) overflow[i] <= 1'b1;
            end
        end
    end

    // Round-robin search: first eligible source starting after the last owner.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = cur_src;
        rr_idx   = cur_src;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            rr_idx = QIDX_WIDTH'((int'(cur_src) + k) % NUM_QUEUES);
            if (!rr_found && eligible[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    // Next-state logic: grant in IDLE, track header/body, release on EOP.
    always_comb begin
        state_next   = state;
        grant_next   = grant;
        cur_src_next = cur_src;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    grant_next   = NUM_QUEUES'(1) << rr_pick;
                    cur_src_next = rr_pick;
                    state_next   = HDR;
                end
            end
            HDR: begin
                if (pop && head_ctrl == '0) state_next = BODY;
            end
            BODY: begin
                if (eop_pop) begin
                    grant_next = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM and grant registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            cur_src <= '0;
        end else begin
            state   <= state_next;
            grant   <= grant_next;
            cur_src <= cur_src_next;
        end
    end

    // Output register toward the IDS stage: one-cycle latency from pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_ctrl <= '0;
            out_wr   <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            out_wr   <= pop;
            pkt_done <= eop_pop;
            if (pop) begin
                out_data <= head_data;
                out_ctrl <= head_ctrl;
            end
        end
    end

endmodule

// File: tb/tb_ids_input_arbiter.sv
// tb_ids_input_arbiter: scenario tasks drive sources; a negedge monitor pops
// an expected-word queue whenever out_wr is seen and compares word, owner and
// pkt_done.
module tb_ids_input_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic          eop;
        logic [1:0]    src;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]    in_wr;
    logic [NQ-1:0]    in_rdy;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_wr;
    logic             out_rdy;
    logic [NQ-1:0]    queue_en;
    logic [NQ-1:0]    grant;
    logic [1:0]       cur_src;
    logic             pkt_done;
    logic [NQ-1:0]    overflow;

    int   checks     = 0;
    int   failures   = 0;
    int   out_wr_cnt = 0;
    int   seq        = 0;
    bit   mon_en     = 1'b0;
    exp_t exp_q[$];
    exp_t hold_q[$];
    exp_t mon_e;

    ids_input_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy),
        .queue_en (queue_en),
        .grant    (grant),
        .cur_src  (cur_src),
        .pkt_done (pkt_done),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every issued word must be the next expected one.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_wr === 1'b1) begin
                out_wr_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got data=%h ctrl=%h src=%0d, required no word",
                             out_data, out_ctrl, cur_src);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_data !== mon_e.data || out_ctrl !== mon_e.ctrl ||
                        cur_src !== mon_e.src || pkt_done !== mon_e.eop) begin
                        failures++;
                        $display("FAIL word: got data=%h ctrl=%h src=%0d pkt_done=%b, required data=%h ctrl=%h src=%0d pkt_done=%b",
                                 out_data, out_ctrl, cur_src, pkt_done,
                                 mon_e.data, mon_e.ctrl, mon_e.src, mon_e.eop);
                    end
                end
            end else begin
                checks++;
                if (pkt_done !== 1'b0) begin
                    failures++;
                    $display("FAIL stray_pkt_done: got pkt_done=%b with out_wr=%b, required 0", pkt_done, out_wr);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One write from one source; optionally waits for in_rdy first.
    task automatic send_word(input int src, input logic [CW-1:0] ctrl,
                             input bit push_exp, input bit eop, input bit wait_rdy);
        logic [DW-1:0] d;
        exp_t          e;
        int            waited;
        d = {4'hA, 4'(src), 24'h0, 32'(seq)};
        seq++;
        waited = 0;
        while (wait_rdy && in_rdy[src] !== 1'b1 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            failures++;
            $display("FAIL in_rdy_timeout: src=%0d in_rdy=%b, required ready within 100 cycles", src, in_rdy);
        end
        in_data[src*DW +: DW] = d;
        in_ctrl[src*CW +: CW] = ctrl;
        in_wr[src]            = 1'b1;
        e.data = d;
        e.ctrl = ctrl;
        e.eop  = eop;
        e.src  = 2'(src);
        if (push_exp) exp_q.push_back(e);
        else          hold_q.push_back(e);
        @(posedge clk);
        #1;
        in_wr[src] = 1'b0;
    endtask

    // Packet of n words: 0xFF header, 0x00 body words, 0x10 EOP.
    task automatic send_pkt(input int src, input int n, input bit push_exp);
        logic [CW-1:0] c;
        for (int w = 0; w < n; w++) begin
            c = (w == 0) ? 8'hFF : ((w == n - 1) ? 8'h10 : 8'h00);
            send_word(src, c, push_exp, (w == n - 1), 1'b1);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        mon_en = 1'b1;
        checks++;
        if (out_wr !== 1'b0 || pkt_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: got out_wr=%b pkt_done=%b, required 0 0", out_wr, pkt_done);
        end
        checks++;
        if (grant !== 4'b0000 || cur_src !== 2'd0) begin
            failures++;
            $display("FAIL reset_grant: got grant=%b cur_src=%0d, required 0000 0", grant, cur_src);
        end
        checks++;
        if (out_data !== '0 || out_ctrl !== '0) begin
            failures++;
            $display("FAIL reset_data: got data=%h ctrl=%h, required 0 0", out_data, out_ctrl);
        end
        checks++;
        if (in_rdy !== 4'b1111 || overflow !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status: got in_rdy=%b overflow=%b, required 1111 0000", in_rdy, overflow);
        end
    endtask

    task automatic test_single_packet();
        send_word(0, 8'hFF, 1'b1, 1'b0, 1'b1);
        checks++;
        if (grant !== 4'b0000) begin
            failures++;
            $display("FAIL arb_cycle: got grant=%b right after first write, required 0000", grant);
        end
        send_word(0, 8'h00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL first_grant: got grant=%b, required 0001", grant);
        end
        send_word(0, 8'h00, 1'b1, 1'b0, 1'b1);
        send_word(0, 8'h00, 1'b1, 1'b0, 1'b1);
        send_word(0, 8'h10, 1'b1, 1'b1, 1'b1);
        wait_drain("single");
        checks++;
        if (grant !== 4'b0000 || cur_src !== 2'd0) begin
            failures++;
            $display("FAIL single_release: got grant=%b cur_src=%0d, required 0000 0", grant, cur_src);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] d1, d3;
        exp_t          e;
        logic [CW-1:0] c;
        send_pkt(1, 3, 1'b1);
        wait_drain("rr_prime");
        checks++;
        if (cur_src !== 2'd1) begin
            failures++;
            $display("FAIL rr_prime_owner: got cur_src=%0d, required 1", cur_src);
        end
        // Both sources written together: source 3 must win, then source 1.
        for (int pass = 0; pass < 2; pass++) begin
            for (int w = 0; w < 3; w++) begin
                c = (w == 0) ? 8'hFF : ((w == 2) ? 8'h10 : 8'h00);
                e.data = {4'hB, 4'(pass == 0 ? 3 : 1), 24'h0, 32'(w)};
                e.ctrl = c;
                e.eop  = (w == 2);
                e.src  = (pass == 0) ? 2'd3 : 2'd1;
                exp_q.push_back(e);
            end
        end
        for (int w = 0; w < 3; w++) begin
            c  = (w == 0) ? 8'hFF : ((w == 2) ? 8'h10 : 8'h00);
            d1 = {4'hB, 4'd1, 24'h0, 32'(w)};
            d3 = {4'hB, 4'd3, 24'h0, 32'(w)};
            in_data[1*DW +: DW] = d1;
            in_data[3*DW +: DW] = d3;
            in_ctrl[1*CW +: CW] = c;
            in_ctrl[3*CW +: CW] = c;
            in_wr = 4'b1010;
            @(posedge clk);
            #1;
        end
        in_wr = 4'b0000;
        wait_drain("rr_pair");
        checks++;
        if (cur_src !== 2'd1 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL rr_final: got cur_src=%0d grant=%b, required 1 0000", cur_src, grant);
        end
    endtask

    task automatic test_stall();
        int base, seen, n;
        base = out_wr_cnt;
        seen = 0;
        fork
            send_pkt(1, 6, 1'b1);
            begin
                n = 0;
                while (out_wr_cnt < base + 2 && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_rdy = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (out_wr === 1'b1) seen++;
                    if (k == 2) begin
                        checks++;
                        if (out_wr !== 1'b0) begin
                            failures++;
                            $display("FAIL stall_quiet: got out_wr=%b in third stall cycle, required 0", out_wr);
                        end
                    end
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        checks++;
        if (seen > 1) begin
            failures++;
            $display("FAIL stall_slack: got %0d words after out_rdy fell, required at most 1", seen);
        end
        wait_drain("stall");
    endtask

    task automatic test_overflow();
        out_rdy = 1'b0;
        send_word(2, 8'hFF, 1'b1, 1'b0, 1'b0);
        send_word(2, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (in_rdy[2] !== 1'b1) begin
            failures++;
            $display("FAIL ovf_rdy2: got in_rdy[2]=%b after 2 words, required 1", in_rdy[2]);
        end
        send_word(2, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (in_rdy[2] !== 1'b0) begin
            failures++;
            $display("FAIL ovf_rdy3: got in_rdy[2]=%b after 3 words, required 0", in_rdy[2]);
        end
        send_word(2, 8'h10, 1'b1, 1'b1, 1'b0);
        checks++;
        if (overflow !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_full_ok: got overflow=%b after 4 words, required 0000", overflow);
        end
        send_word(2, 8'h00, 1'b0, 1'b0, 1'b0);
        hold_q.delete();
        checks++;
        if (overflow !== 4'b0100) begin
            failures++;
            $display("FAIL ovf_set: got overflow=%b after 5th word, required 0100", overflow);
        end
        repeat (3) @(posedge clk);
        #1;
        out_rdy = 1'b1;
        wait_drain("ovf");
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (overflow !== 4'b0100) begin
            failures++;
            $display("FAIL ovf_sticky: got overflow=%b, required 0100", overflow);
        end
        do_reset();
        checks++;
        if (overflow !== 4'b0000 || in_rdy !== 4'b1111) begin
            failures++;
            $display("FAIL ovf_clear: got overflow=%b in_rdy=%b, required 0000 1111", overflow, in_rdy);
        end
    endtask

    task automatic test_queue_en();
        int n;
        fork
            send_pkt(0, 6, 1'b1);
            begin
                n = 0;
                while (grant[0] !== 1'b1 && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (grant[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL qen_grant: got grant=%b, required bit 0 set", grant);
                end
                queue_en[0] = 1'b0;
            end
        join
        wait_drain("qen_active");
        send_pkt(0, 3, 1'b0);
        send_pkt(1, 3, 1'b1);
        wait_drain("qen_other");
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000 || in_rdy[0] !== 1'b0) begin
            failures++;
            $display("FAIL qen_blocked: got grant=%b in_rdy[0]=%b, required 0000 0", grant, in_rdy[0]);
        end
        while (hold_q.size() != 0) exp_q.push_back(hold_q.pop_front());
        queue_en[0] = 1'b1;
        wait_drain("qen_resume");
        checks++;
        if (in_rdy !== 4'b1111 || cur_src !== 2'd0) begin
            failures++;
            $display("FAIL qen_resume_state: got in_rdy=%b cur_src=%0d, required 1111 0", in_rdy, cur_src);
        end
    endtask

    task automatic test_reset_mid_packet();
        send_word(3, 8'hFF, 1'b1, 1'b0, 1'b1);
        send_word(3, 8'h00, 1'b1, 1'b0, 1'b1);
        wait_drain("mid_pre");
        out_rdy = 1'b0;
        send_word(3, 8'h00, 1'b0, 1'b0, 1'b1);
        send_word(3, 8'h00, 1'b0, 1'b0, 1'b1);
        hold_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (grant !== 4'b0000 || out_wr !== 1'b0 || in_rdy !== 4'b1111) begin
            failures++;
            $display("FAIL mid_reset: got grant=%b out_wr=%b in_rdy=%b, required 0000 0 1111",
                     grant, out_wr, in_rdy);
        end
        out_rdy = 1'b1;
        send_pkt(3, 4, 1'b1);
        wait_drain("mid_after");
        checks++;
        if (grant !== 4'b0000 || cur_src !== 2'd3) begin
            failures++;
            $display("FAIL mid_after_state: got grant=%b cur_src=%0d, required 0000 3", grant, cur_src);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = '0;
        in_ctrl  = '0;
        in_wr    = '0;
        out_rdy  = 1'b1;
        queue_en = 4'b1111;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_stall();
        test_overflow();
        test_queue_en();
        test_reset_mid_packet();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
